// File: rtl/bus_arb.sv
// Two-master shared-bus arbiter: video DMA (m0) has priority, but the CPU (m1) is
// guaranteed a grant after MAX_CONSEC back-to-back m0 grants. Granted transfers that
// wait TIMEOUT cycles without s_ack are aborted with an error pulse.
module bus_arb #(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned MAX_CONSEC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [21:0] m0_addr,
    input  logic [31:0] m0_dout,
    output logic [31:0] m0_din,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [21:0] m1_addr,
    input  logic [31:0] m1_dout,
    output logic [31:0] m1_din,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        s_stb,
    output logic        s_we,
    output logic [21:0] s_addr,
    output logic [31:0] s_dout,
    input  logic [31:0] s_din,
    input  logic        s_ack,
    output logic        tmo,
    output logic [21:0] tmo_addr
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StRel} state_e;

    localparam logic [9:0] TimeoutLast = 10'(TIMEOUT - 1);
    localparam logic [3:0] MaxConsec   = 4'(MAX_CONSEC);

    state_e      state_q, state_d;
    logic [3:0]  consec_q, consec_d;
    logic [9:0]  wait_cnt_q, wait_cnt_d;
    logic [21:0] tmo_addr_q, tmo_addr_d;

    // Signals of whichever master currently owns the bus.
    logic        g_stb, g_we;
    logic [21:0] g_addr;
    logic [31:0] g_dout;
    logic        timeout, g_ack;
    logic [31:0] g_din;

    assign g_stb  = (state_q == StGnt1) ? m1_stb  : m0_stb;
    assign g_we   = (state_q == StGnt1) ? m1_we   : m0_we;
    assign g_addr = (state_q == StGnt1) ? m1_addr : m0_addr;
    assign g_dout = (state_q == StGnt1) ? m1_dout : m0_dout;

    // Tracks the last aborted address; hidden while reset is held.
    assign tmo_addr = rst_n ? tmo_addr_q : '0;

    // Arbitration, grant routing, timeout detection and counter next-state.
    always_comb begin
        state_d    = state_q;
        consec_d   = consec_q;
        wait_cnt_d = wait_cnt_q;
        tmo_addr_d = tmo_addr_q;
        timeout    = 1'b0;
        g_ack      = 1'b0;
        g_din      = '0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_addr     = '0;
        s_dout     = '0;
        m0_din     = '0;
        m0_ack     = 1'b0;
        m0_err     = 1'b0;
        m1_din     = '0;
        m1_ack     = 1'b0;
        m1_err     = 1'b0;
        tmo        = 1'b0;

        unique case (state_q)
            StIdle: begin
                wait_cnt_d = '0;
                if (m0_stb && (!m1_stb || consec_q < MaxConsec)) begin
                    state_d  = StGnt0;
                    // Only count m0 wins that actually made m1 wait.
                    if (m1_stb) begin
                        consec_d = (consec_q == 4'hF) ? consec_q : consec_q + 4'd1;
                    end else begin
                        consec_d = '0;
                    end
                end else if (m1_stb) begin
                    state_d  = StGnt1;
                    consec_d = '0;
                end else begin
                    consec_d = '0;
                end
            end
            StGnt0, StGnt1: begin
                // A real ack in the last allowed cycle beats the abort.
                timeout = !s_ack && (wait_cnt_q == TimeoutLast);
                g_ack   = s_ack || timeout;
                g_din   = timeout ? 32'h0 : s_din;
                s_stb   = g_stb && !timeout;
                s_we    = g_we;
                s_addr  = g_addr;
                s_dout  = g_dout;
                tmo     = timeout;
                if (state_q == StGnt0) begin
                    m0_din = g_din;
                    m0_ack = g_ack;
                    m0_err = timeout;
                end else begin
                    m1_din = g_din;
                    m1_ack = g_ack;
                    m1_err = timeout;
                end
                if (s_ack || timeout || !g_stb) begin
                    state_d = StRel;
                    if (timeout) begin
                        tmo_addr_d = g_addr;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 10'd1;
                end
            end
            StRel: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Holding reset silences the bus, including any transfer in flight.
        if (!rst_n) begin
            s_stb  = 1'b0;
            s_we   = 1'b0;
            s_addr = '0;
            s_dout = '0;
            m0_din = '0;
            m0_ack = 1'b0;
            m0_err = 1'b0;
            m1_din = '0;
            m1_ack = 1'b0;
            m1_err = 1'b0;
            tmo    = 1'b0;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            consec_q   <= '0;
            wait_cnt_q <= '0;
            tmo_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            consec_q   <= consec_d;
            wait_cnt_q <= wait_cnt_d;
            tmo_addr_q <= tmo_addr_d;
        end
    end

endmodule

// File: tb/tb_bus_arb.sv
// Self-checking bench for bus_arb: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a transaction-level reference model.
module tb_bus_arb;

    localparam int unsigned TIMEOUT    = 255;
    localparam int unsigned MAX_CONSEC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_stb, m0_we, m1_stb, m1_we, s_ack;
    logic [21:0] m0_addr, m1_addr;
    logic [31:0] m0_dout, m1_dout, s_din;
    logic [31:0] m0_din, m1_din, s_dout;
    logic        m0_ack, m0_err, m1_ack, m1_err, s_stb, s_we, tmo;
    logic [21:0] s_addr, tmo_addr;

    always #5 clk = ~clk;

    bus_arb #(
        .TIMEOUT    (TIMEOUT),
        .MAX_CONSEC (MAX_CONSEC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_dout  (m0_dout),
        .m0_din   (m0_din),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_dout  (m1_dout),
        .m1_din   (m1_din),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_dout   (s_dout),
        .s_din    (s_din),
        .s_ack    (s_ack),
        .tmo      (tmo),
        .tmo_addr (tmo_addr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the bus (-1 = nobody), whether we are in the
    // mandatory dead cycle after a transfer, and the fairness / wait counts.
    int          owner = -1;
    bit          in_rel = 1'b0;
    int          consec = 0;
    int          waited = 0;
    logic [21:0] mtmo_addr = '0;

    // DUT values captured at the last sample point, for scenario-level checks.
    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_tmo, o_s_stb;
    logic [31:0] o_m1_din;
    logic [21:0] o_s_addr, o_tmo_addr;
    bit          x_m0_ack = 1'b0, x_m1_ack = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs at the falling edge, advance the model, then
    // return just after the rising edge so the caller can drive new inputs.
    task automatic step();
        logic        stb, we, to, ack;
        logic [21:0] addr;
        logic [31:0] dout, din;
        logic [33:0] e_m0, e_m1;
        logic [55:0] e_bus;
        logic [22:0] e_tmo;
        @(negedge clk);
        stb = 1'b0; we = 1'b0; to = 1'b0; ack = 1'b0; addr = '0; dout = '0; din = '0;
        e_m0 = '0; e_m1 = '0; e_bus = '0;
        if (rst_n && owner >= 0) begin
            stb   = (owner == 1) ? m1_stb  : m0_stb;
            we    = (owner == 1) ? m1_we   : m0_we;
            addr  = (owner == 1) ? m1_addr : m0_addr;
            dout  = (owner == 1) ? m1_dout : m0_dout;
            to    = !s_ack && (waited == int'(TIMEOUT) - 1);
            ack   = s_ack || to;
            din   = to ? 32'h0 : s_din;
            e_bus = {stb && !to, we, addr, dout};
            if (owner == 0) e_m0 = {din, ack, to};
            else            e_m1 = {din, ack, to};
        end
        e_tmo = {to, rst_n ? mtmo_addr : 22'h0};
        check("m0_side", {m0_din, m0_ack, m0_err}, e_m0);
        check("m1_side", {m1_din, m1_ack, m1_err}, e_m1);
        check("bus_side", {s_stb, s_we, s_addr, s_dout}, e_bus);
        check("tmo_out", {tmo, tmo_addr}, e_tmo);
        o_m0_ack = m0_ack; o_m0_err = m0_err; o_m1_ack = m1_ack; o_m1_err = m1_err;
        o_tmo = tmo; o_s_stb = s_stb; o_m1_din = m1_din; o_s_addr = s_addr;
        o_tmo_addr = tmo_addr;
        x_m0_ack = e_m0[1];
        x_m1_ack = e_m1[1];

        if (!rst_n) begin
            owner = -1; in_rel = 1'b0; consec = 0; waited = 0; mtmo_addr = '0;
        end else if (in_rel) begin
            in_rel = 1'b0;
        end else if (owner < 0) begin
            waited = 0;
            if (m0_stb && (!m1_stb || consec < int'(MAX_CONSEC))) begin
                owner  = 0;
                consec = m1_stb ? ((consec < 15) ? consec + 1 : 15) : 0;
            end else if (m1_stb) begin
                owner  = 1;
                consec = 0;
            end else begin
                consec = 0;
            end
        end else if (s_ack || to || !stb) begin
            if (to) mtmo_addr = addr;
            owner  = -1;
            in_rel = 1'b1;
        end else begin
            waited++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq[$];
        int exp_seq[6];
        int n;
        exp_seq = '{0, 0, 0, 0, 1, 0};
        rst_n = 1'b0;
        m0_stb = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_dout = '0;
        m1_stb = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_dout = '0;
        s_ack = 1'b0; s_din = '0;
        @(posedge clk);
        #1;

        // Reset, then idle with reset released.
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // m1 alone reads; slave answers on the third strobe cycle.
        m1_stb = 1'b1; m1_we = 1'b0; m1_addr = 22'h000100;
        step();
        check("m1_req_latency", o_s_stb, 1'b0);
        step();
        check("m1_granted", o_s_stb, 1'b1);
        step();
        s_ack = 1'b1; s_din = 32'hDEADBEEF;
        step();
        check("m1_rd_ack", o_m1_ack, 1'b1);
        check("m1_rd_data", o_m1_din, 32'hDEADBEEF);
        m1_stb = 1'b0; s_ack = 1'b0; s_din = '0;
        step();
        check("rel_no_stb", o_s_stb, 1'b0);
        step();

        // Simultaneous requests: m0 first, m1 follows after the REL and IDLE cycles.
        m0_stb = 1'b1; m0_addr = 22'h0000AA; m1_stb = 1'b1; m1_addr = 22'h000155;
        step();
        step();
        s_ack = 1'b1; s_din = 32'h12345678;
        step();
        check("m0_first_ack", {o_m0_ack, o_m1_ack}, 2'b10);
        m0_stb = 1'b0; s_ack = 1'b0;
        step();
        check("gap_rel", o_s_stb, 1'b0);
        step();
        check("gap_idle", o_s_stb, 1'b0);
        step();
        check("m1_second", {o_s_stb, o_s_addr}, {1'b1, 22'h000155});
        s_ack = 1'b1;
        step();
        m1_stb = 1'b0; s_ack = 1'b0;
        step();
        step();

        // Starvation guard: m0 streams while m1 waits.
        step();
        m0_stb = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
        for (int i = 0; i < 40 && seq.size() < 6; i++) begin
            step();
            if (o_m0_ack) seq.push_back(0);
            if (o_m1_ack) begin
                seq.push_back(1);
                m1_stb = 1'b0;
            end
        end
        check("burst_len", seq.size(), 6);
        for (int i = 0; i < seq.size() && i < 6; i++) begin
            check($sformatf("burst_owner[%0d]", i), seq[i], exp_seq[i]);
        end
        m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
        repeat (3) step();

        // m1 write that the slave never acknowledges.
        m1_stb = 1'b1; m1_we = 1'b1; m1_addr = 22'h3FFFF1; m1_dout = $urandom;
        step();
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            step();
            if (o_m1_ack) begin
                n = i;
                break;
            end
        end
        check("tmo_cycle", n, 255);
        check("tmo_err", {o_m1_err, o_tmo}, 2'b11);
        m1_stb = 1'b0; m1_we = 1'b0;
        step();
        check("tmo_addr", o_tmo_addr, 22'h3FFFF1);
        step();

        // Reset while m0 is waiting for its ack.
        m0_stb = 1'b1; m0_addr = 22'h001234;
        repeat (3) step();
        rst_n = 1'b0; m0_stb = 1'b0;
        step();
        check("rst_no_ack", o_m0_ack, 1'b0);
        rst_n = 1'b1;
        step();
        check("rst_idle", {o_s_stb, o_m0_ack, o_m0_err}, 3'b000);

        // m0 abandons its transfer before the slave answers.
        m0_stb = 1'b1; m0_addr = 22'h002222;
        step();
        step();
        m0_stb = 1'b0;
        step();
        check("abandon_quiet", {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}, 4'b0000);
        step();
        step();

        // Randomized traffic: masters hold stb until acked, occasionally abandon;
        // the slave acks randomly; reset is pulsed now and then.
        for (int i = 0; i < 3000; i++) begin
            if (x_m0_ack) m0_stb = 1'b0;
            else if (m0_stb) begin
                if ($urandom_range(0, 39) == 0) m0_stb = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                m0_stb = 1'b1; m0_we = 1'($urandom);
                m0_addr = 22'($urandom); m0_dout = $urandom;
            end
            if (x_m1_ack) m1_stb = 1'b0;
            else if (m1_stb) begin
                if ($urandom_range(0, 39) == 0) m1_stb = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                m1_stb = 1'b1; m1_we = 1'($urandom);
                m1_addr = 22'($urandom); m1_dout = $urandom;
            end
            s_ack = ($urandom_range(0, 2) == 0);
            s_din = $urandom;
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
